// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pool
// sequencing controller.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } pool_state_t;

  function automatic int out_dim(
    input int img,
    input int k,
    input int s
  );
    return (img - k) / s + 1;
  endfunction

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_pos_cnt.sv
// One raster axis: position, wrap, "window reached"
// flag and stride phase tracked without a divider.
module pool_pos_cnt
  import pool_pkg::*;
#(
  parameter int DIM = 13,
  parameter int K   = 3,
  parameter int S   = 2,
  localparam int W  = cw(DIM),
  localparam int PW = cw(S)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap,
  output logic o_ge,
  output logic o_ph0
);

  localparam logic [W-1:0]  LAST  = W'(DIM - 1);
  localparam logic [W-1:0]  KM1   = W'(K - 1);
  localparam logic [PW-1:0] PLAST = PW'(S - 1);

  logic [W-1:0]  r_pos;
  logic [PW-1:0] r_ph;
  logic          w_last;

  assign w_last = (r_pos == LAST);
  assign o_wrap = i_en && w_last;
  assign o_ge   = (r_pos >= KM1);
  assign o_ph0  = (r_ph == '0);

  // phase only runs once the window edge is reached
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos <= '0;
      r_ph  <= '0;
    end else if (i_clr) begin
      r_pos <= '0;
      r_ph  <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_pos <= '0;
        r_ph  <= '0;
      end else begin
        r_pos <= r_pos + 1'b1;
        if (o_ge)
          r_ph <= (r_ph == PLAST) ? '0 : r_ph + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_ctrl.sv
// Max-pool sequencer: raster tracking, window strobe
// and per-image start/ready handshake.
module pool_ctrl
  import pool_pkg::*;
#(
  parameter int IMG_DIM     = 13,
  parameter int KERNEL_DIM  = 3,
  parameter int STRIDE      = 2,
  localparam int OUT_DIM    =
    out_dim(IMG_DIM, KERNEL_DIM, STRIDE),
  localparam int OW         = cw(OUT_DIM * OUT_DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  output logic          o_ready,
  input  logic          i_pix_we,
  input  logic          i_next_ready,
  output logic          o_next_we,
  output logic [OW-1:0] o_out_idx,
  output logic          o_next_start,
  output logic          o_busy,
  output logic          o_err
);

  pool_state_t r_state;
  pool_state_t w_nxt;

  logic          w_acc;
  logic          w_pix;
  logic          w_win;
  logic          w_err_ev;
  logic          w_ready;
  logic          w_col_wrap;
  logic          w_col_ge;
  logic          w_col_ph0;
  logic          w_row_wrap;
  logic          w_row_ge;
  logic          w_row_ph0;
  logic          r_next_we;
  logic [OW-1:0] r_out_idx;
  logic [OW-1:0] r_out_cnt;
  logic          r_err;

  assign w_acc = (r_state == IDLE)
              && i_start && i_next_ready;
  assign w_pix = (r_state == FILL) && i_pix_we;

  pool_pos_cnt #(
    .DIM (IMG_DIM),
    .K   (KERNEL_DIM),
    .S   (STRIDE)
  ) u_col (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_acc),
    .i_en   (w_pix),
    .o_wrap (w_col_wrap),
    .o_ge   (w_col_ge),
    .o_ph0  (w_col_ph0)
  );

  pool_pos_cnt #(
    .DIM (IMG_DIM),
    .K   (KERNEL_DIM),
    .S   (STRIDE)
  ) u_row (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_acc),
    .i_en   (w_col_wrap),
    .o_wrap (w_row_wrap),
    .o_ge   (w_row_ge),
    .o_ph0  (w_row_ph0)
  );

  assign w_win = w_pix
              && w_row_ge && w_row_ph0
              && w_col_ge && w_col_ph0;

  assign w_err_ev =
      (i_pix_we && (r_state != FILL))
   || (i_start && (r_state != IDLE));

  // row wrap coincides with the final pixel write
  always_comb begin
    w_nxt   = r_state;
    w_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = i_next_ready;
        if (w_acc)
          w_nxt = FILL;
      end
      FILL: begin
        w_ready = i_next_ready;
        if (w_row_wrap)
          w_nxt = DRAIN;
      end
      DRAIN: w_nxt = DONE;
      DONE:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_next_we <= 1'b0;
      r_out_idx <= '0;
      r_out_cnt <= '0;
    end else begin
      r_next_we <= w_win;
      if (w_acc)
        r_out_cnt <= '0;
      else if (w_win)
        r_out_cnt <= r_out_cnt + 1'b1;
      if (w_win)
        r_out_idx <= r_out_cnt;
    end
  end

  // a fresh start clears, a same-cycle violation wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else
      r_err <= (r_err && !w_acc) || w_err_ev;
  end

  assign o_ready      = w_ready;
  assign o_next_we    = r_next_we;
  assign o_out_idx    = r_out_idx;
  assign o_next_start = (r_state == DONE);
  assign o_busy       = (r_state != IDLE);
  assign o_err        = r_err;

endmodule

// File: tb/tb_pool_ctrl.sv
// Scoreboard bench for pool_ctrl: default 13/3/2
// instance plus a 4/2/2 instance.
module tb_pool_ctrl;

  typedef struct {
    int idx;
    int edg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s0 = 0, pw0 = 0, nr0 = 0;
  logic s1 = 0, pw1 = 0, nr1 = 0;
  logic rd0, we0, ns0, bz0, er0;
  logic rd1, we1, ns1, bz1, er1;
  logic [5:0] ix0;
  logic [1:0] ix1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int np0 = 0, np1 = 0;
  int p0 = 0, p1 = 0, oi0 = 0, oi1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  int sq0[$];
  int sq1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_ctrl u0 (
    .clk          (clk),
    .rst          (rst),
    .i_start      (s0),
    .o_ready      (rd0),
    .i_pix_we     (pw0),
    .i_next_ready (nr0),
    .o_next_we    (we0),
    .o_out_idx    (ix0),
    .o_next_start (ns0),
    .o_busy       (bz0),
    .o_err        (er0)
  );

  pool_ctrl #(
    .IMG_DIM    (4),
    .KERNEL_DIM (2),
    .STRIDE     (2)
  ) u1 (
    .clk          (clk),
    .rst          (rst),
    .i_start      (s1),
    .o_ready      (rd1),
    .i_pix_we     (pw1),
    .i_next_ready (nr1),
    .o_next_we    (we1),
    .o_out_idx    (ix1),
    .o_next_start (ns1),
    .o_busy       (bz1),
    .o_err        (er1)
  );

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic fail(input string nm,
                      input int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d expected none",
             nm, act);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (we0) begin
      np0++;
      if (q0.size() == 0)
        fail("u0_unexpected_we", ix0);
      else begin
        e = q0.pop_front();
        chk("u0_idx", ix0, e.idx);
        chk("u0_we_cycle", cyc, e.edg);
      end
    end
    if (ns0) begin
      if (sq0.size() == 0)
        fail("u0_unexpected_start", cyc);
      else
        chk("u0_start_cycle", cyc, sq0.pop_front());
    end
    if (we1) begin
      np1++;
      if (q1.size() == 0)
        fail("u1_unexpected_we", ix1);
      else begin
        e = q1.pop_front();
        chk("u1_idx", ix1, e.idx);
        chk("u1_we_cycle", cyc, e.edg);
      end
    end
    if (ns1) begin
      if (sq1.size() == 0)
        fail("u1_unexpected_start", cyc);
      else
        chk("u1_start_cycle", cyc, sq1.pop_front());
    end
  end

  task automatic drv(input int d,
                     input bit st,
                     input bit we);
    @(negedge clk);
    if (d == 0) begin
      s0 = st;
      pw0 = we;
    end else begin
      s1 = st;
      pw1 = we;
    end
  endtask

  // pixel write; expectations derived from raster pos
  task automatic pix(input int d, input bit we);
    int r, c;
    drv(d, 1'b0, we);
    if (we) begin
      if (d == 0) begin
        r = p0 / 13;
        c = p0 % 13;
        if (r >= 2 && c >= 2 &&
            (r - 2) % 2 == 0 && (c - 2) % 2 == 0) begin
          q0.push_back('{oi0, cyc + 1});
          oi0++;
        end
        if (p0 == 168)
          sq0.push_back(cyc + 2);
        p0++;
      end else begin
        if (p1 == 5 || p1 == 7 ||
            p1 == 13 || p1 == 15) begin
          q1.push_back('{oi1, cyc + 1});
          oi1++;
        end
        if (p1 == 15)
          sq1.push_back(cyc + 2);
        p1++;
      end
    end
  endtask

  task automatic start(input int d);
    if (d == 0) begin
      p0 = 0;
      oi0 = 0;
    end else begin
      p1 = 0;
      oi1 = 0;
    end
    drv(d, 1'b1, 1'b0);
    drv(d, 1'b0, 1'b0);
    chk("start_busy", d == 0 ? bz0 : bz1, 1);
    chk("start_err_clr", d == 0 ? er0 : er1, 0);
  endtask

  task automatic img(input int d,
                     input bit gap,
                     input int err_at);
    int n, snap, ea;
    n = (d == 0) ? 169 : 16;
    snap = (d == 0) ? np0 : np1;
    ea = err_at;
    start(d);
    while (((d == 0) ? p0 : p1) < n) begin
      if (ea >= 0 && ((d == 0) ? p0 : p1) == ea) begin
        drv(d, 1'b1, 1'b0);
        ea = -1;
      end
      pix(d, gap ? ($urandom_range(0, 2) == 0) : 1'b1);
    end
    pix(d, 1'b0);
    chk("drain_ready", d == 0 ? rd0 : rd1, 0);
    chk("drain_busy", d == 0 ? bz0 : bz1, 1);
    pix(d, 1'b0);
    chk("done_ready", d == 0 ? rd0 : rd1, 0);
    pix(d, 1'b0);
    chk("idle_ready", d == 0 ? rd0 : rd1, 1);
    chk("idle_busy", d == 0 ? bz0 : bz1, 0);
    chk("pulse_count",
        ((d == 0) ? np0 : np1) - snap,
        (d == 0) ? 36 : 4);
    chk("pending_we",
        (d == 0) ? q0.size() : q1.size(), 0);
    chk("pending_start",
        (d == 0) ? sq0.size() : sq1.size(), 0);
    if (err_at >= 0)
      chk("err_sticky", d == 0 ? er0 : er1, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we", we0, 0);
    chk("rst_idx", ix0, 0);
    chk("rst_start", ns0, 0);
    chk("rst_busy", bz0, 0);
    chk("rst_err", er0, 0);
    chk("rst_ready", rd0, 0);
    @(negedge clk);
    rst = 1'b1;

    drv(0, 1'b1, 1'b0);
    drv(0, 1'b0, 1'b0);
    chk("nready_busy", bz0, 0);
    chk("nready_ready", rd0, 0);
    nr0 = 1'b1;
    #1;
    chk("ready_follow", rd0, 1);

    img(0, 1'b0, -1);
    img(0, 1'b1, -1);

    drv(0, 1'b0, 1'b1);
    drv(0, 1'b0, 1'b0);
    chk("idle_pix_err", er0, 1);
    img(0, 1'b0, 50);

    start(0);
    repeat (100) pix(0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_we", we0, 0);
    chk("arst_idx", ix0, 0);
    chk("arst_start", ns0, 0);
    chk("arst_busy", bz0, 0);
    chk("arst_err", er0, 0);
    q0.delete();
    sq0.delete();
    pw0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    img(0, 1'b0, -1);

    nr1 = 1'b1;
    img(1, 1'b0, -1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pool_ctrl.md
# pool_ctrl

Sequencing controller for the streaming max-pool datapath. It tracks the raster position of each pixel written into the pool line buffer and raises the downstream write strobe only on cycles where the K×K window is complete and stride-aligned. It also runs the per-image start/ready handshake between the upstream layer, the pool datapath and the next layer. It sits beside the pool datapath, between its input-buffer write port and the next layer's input buffer.

## Interface
Parameters:
- IMG_DIM, 13, input image width/height (square image)
- KERNEL_DIM, 3, pooling window edge K
- STRIDE, 2, window step in both axes (1..KERNEL_DIM)
- OUT_DIM, (IMG_DIM-KERNEL_DIM)/STRIDE+1, output width/height (derived, not overridden)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- i_start  input  1  upstream start pulse: a new image follows
- o_ready  output  1  controller and downstream can accept start/pixels
- i_pix_we  input  1  one pixel (all channels) written into the line buffer this cycle
- i_next_ready  input  1  next layer ready
- o_next_we  output  1  pool datapath output is a valid pooled pixel this cycle
- o_out_idx  output  $clog2(OUT_DIM**2)  raster index of the pooled pixel; valid with o_next_we
- o_next_start  output  1  one-cycle pulse: image fully pooled
- o_busy  output  1  image in progress
- o_err  output  1  sticky protocol error

## Operation
- States: IDLE, FILL, DRAIN, DONE. Reset: IDLE, all counters 0, all outputs 0.
- IDLE: o_ready = i_next_ready. An accepted start (i_start && i_next_ready) -> FILL, clears row/col/out counters and o_err. i_start while !i_next_ready is ignored.
- FILL: o_ready = i_next_ready, o_busy = 1. Each i_pix_we advances col; when col = IMG_DIM-1, col wraps to 0 and row increments.
- Window valid on the write of pixel (r,c) iff r ≥ K-1, c ≥ K-1, (r-(K-1)) mod STRIDE = 0 and (c-(K-1)) mod STRIDE = 0. The mod is computed with per-axis phase counters; no divider is used.
- Each valid window increments out_idx, which starts at 0 and ends at OUT_DIM²-1.
- The write of pixel (IMG_DIM-1, IMG_DIM-1) -> DRAIN. DRAIN lasts 1 cycle -> DONE.
- DONE: o_next_start = 1 for 1 cycle -> IDLE.
- o_ready = 0 in DRAIN and DONE.
- i_pix_we in FILL is always honoured, even with o_ready low, because the datapath cannot stall.
- i_pix_we in IDLE/DRAIN/DONE: pixel not counted, o_err set.
- i_start outside IDLE: ignored, o_err set.
- No stale-data masking is needed: the first valid window needs IMG_DIM*(K-1)+K pixels, which equals the line-buffer length, so stale buffer contents never reach a valid output.

## Timing
- Pixel write at cycle t -> o_next_we and o_out_idx registered at t+1. This aligns with the datapath's combinational max of the updated buffer.
- Last pixel at t: o_next_we at t+1 (DRAIN), o_next_start at t+2 (DONE), o_ready possible again at t+3.
- Start accepted at t: pixels are counted from t+1. i_pix_we in the same cycle as i_start is an error (state still IDLE).
- Back-to-back images: i_start in the cycle the state is IDLE is accepted, giving a minimum 3-cycle gap after the last pixel.
- Reset mid-image: asynchronous return to IDLE, outputs 0 immediately, no o_next_start.
- Counter widths: row/col $clog2(IMG_DIM); phase $clog2(STRIDE) (minimum 1 bit); no overflow past IMG_DIM-1.

## Structure
- pool_pkg holds:
  - pool_state_t enum (IDLE, FILL, DRAIN, DONE)
  - function out_dim(img, k, s)
- Sub-module pool_pos_cnt: one axis position counter. Provides wrap output, a "≥ K-1" flag and a stride phase-zero flag. Instantiated twice: col, and row (row enabled by col wrap).
- Output strobes are registered in pool_ctrl.

## Test plan
- Defaults, 169 pixels back-to-back:
  - exactly 36 o_next_we pulses
  - first pulse 1 cycle after pixel 28 (r2,c2)
  - pulses at c ∈ {2,4,…,12}
  - o_out_idx 0..35 in order
  - o_next_start 2 cycles after the last pixel
- Gapped pixels (i_pix_we 1-of-3 random) -> identical o_out_idx sequence and pulse count; each pulse 1 cycle after its pixel.
- i_next_ready low at i_start -> no transition, o_ready 0. Raise ready -> start accepted, o_busy 1 next cycle.
- i_pix_we in IDLE, i_start during FILL -> o_err 1, counts unaffected. Next accepted start clears o_err.
- rst asserted at pixel 100 -> all outputs 0 asynchronously. A new image after release gives 36 pulses from index 0.
- IMG_DIM=4, KERNEL_DIM=2, STRIDE=2 -> 4 pulses, at pixel writes (1,1),(1,3),(3,1),(3,3).
